// File: rtl/sweep_ctrl.sv
// Sequencer for an up/down counter: runs a triangular sweep between latched
// bounds lo..hi for a programmed number of round trips, or until stopped.
module sweep_ctrl #(
    parameter int W  = 17,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [TW-1:0] sweeps,
    input  logic [W-1:0]  cnt,
    output logic          cnt_en,
    output logic          cnt_dir,
    output logic          cnt_zero,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [TW-1:0] trips
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SEEK  = 3'd2;
    localparam logic [2:0] S_UP    = 3'd3;
    localparam logic [2:0] S_DOWN  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    logic [2:0]    state_r;
    logic [W-1:0]  lo_r;
    logic [W-1:0]  hi_r;
    logic [TW-1:0] sweeps_r;
    logic [TW-1:0] trips_r;
    logic          cnt_en_r;
    logic          cnt_dir_r;
    logic          cnt_zero_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;

    logic [2:0]    state_nxt_s;
    logic          latch_s;
    logic          err_s;
    logic          trip_inc_s;
    logic [TW:0]   trips_p1_s;
    logic [TW-1:0] trips_sat_s;
    logic          last_trip_s;
    logic          en_nxt_s;
    logic          dir_nxt_s;
    logic          zero_nxt_s;

    // Trip arithmetic: saturating increment and final-trip detection
    always_comb begin
        trips_p1_s  = {1'b0, trips_r} + {{TW{1'b0}}, 1'b1};
        trips_sat_s = trips_p1_s[TW] ? trips_r : trips_p1_s[TW-1:0];
        last_trip_s = (sweeps_r != {TW{1'b0}}) && (trips_p1_s == {1'b0, sweeps_r});
    end

    // Next-state logic; the counter moves on the same edge as the state
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        err_s       = 1'b0;
        trip_inc_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && !stop) begin
                    if (lo < hi) begin
                        state_nxt_s = S_CLEAR;
                        latch_s     = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (stop) begin
                    state_nxt_s = S_IDLE;
                end else if (lo_r != {W{1'b0}}) begin
                    state_nxt_s = S_SEEK;
                end else begin
                    state_nxt_s = S_UP;
                end
            end
            S_SEEK: begin
                if (stop) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt == lo_r - ONE_W) begin
                    state_nxt_s = S_UP;
                end else begin
                    state_nxt_s = S_SEEK;
                end
            end
            S_UP: begin
                if (stop) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt == hi_r - ONE_W) begin
                    state_nxt_s = S_DOWN;
                end else begin
                    state_nxt_s = S_UP;
                end
            end
            S_DOWN: begin
                if (stop) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt == lo_r + ONE_W) begin
                    trip_inc_s  = 1'b1;
                    state_nxt_s = last_trip_s ? S_DONE : S_UP;
                end else begin
                    state_nxt_s = S_DOWN;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Counter-control decode of the upcoming state so the outputs leave a flop
    always_comb begin
        en_nxt_s   = 1'b0;
        dir_nxt_s  = 1'b0;
        zero_nxt_s = 1'b0;
        case (state_nxt_s)
            S_CLEAR: zero_nxt_s = 1'b1;
            S_SEEK: begin
                en_nxt_s  = 1'b1;
                dir_nxt_s = 1'b1;
            end
            S_UP: begin
                en_nxt_s  = 1'b1;
                dir_nxt_s = 1'b1;
            end
            S_DOWN: en_nxt_s = 1'b1;
            default: begin
                en_nxt_s   = 1'b0;
                dir_nxt_s  = 1'b0;
                zero_nxt_s = 1'b0;
            end
        endcase
    end

    // State, latched run parameters, trip counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            lo_r       <= {W{1'b0}};
            hi_r       <= {W{1'b0}};
            sweeps_r   <= {TW{1'b0}};
            trips_r    <= {TW{1'b0}};
            cnt_en_r   <= 1'b0;
            cnt_dir_r  <= 1'b0;
            cnt_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (latch_s) begin
                lo_r     <= lo;
                hi_r     <= hi;
                sweeps_r <= sweeps;
                trips_r  <= {TW{1'b0}};
            end else if (trip_inc_s) begin
                trips_r <= trips_sat_s;
            end
            cnt_en_r   <= en_nxt_s;
            cnt_dir_r  <= dir_nxt_s;
            cnt_zero_r <= zero_nxt_s;
            busy_r     <= (state_nxt_s != S_IDLE);
            done_r     <= (state_nxt_s == S_DONE);
            err_r      <= err_s;
        end
    end

    assign cnt_en   = cnt_en_r;
    assign cnt_dir  = cnt_dir_r;
    assign cnt_zero = cnt_zero_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign trips    = trips_r;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl with a behavioural counter closing the loop
// and a scoreboard queue of expected per-cycle counter/trip/done values.
module tb_sweep_ctrl;

    typedef struct packed {
        logic [16:0] c;
        logic [7:0]  t;
        logic        d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [16:0] lo_i;
    logic [16:0] hi_i;
    logic [7:0]  sweeps_i;
    logic [16:0] cnt = 17'd77;
    logic        cnt_en;
    logic        cnt_dir;
    logic        cnt_zero;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  trips;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    sweep_ctrl #(.W(17), .TW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .lo(lo_i), .hi(hi_i), .sweeps(sweeps_i), .cnt(cnt),
        .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_zero(cnt_zero),
        .busy(busy), .done(done), .err(err), .trips(trips)
    );

    always #5 clk = ~clk;

    // External counter: clear overrides counting, no reset of its own here
    always_ff @(posedge clk) begin
        if (cnt_zero) cnt <= 17'd0;
        else if (cnt_en) cnt <= cnt_dir ? cnt + 17'd1 : cnt - 17'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Push the ideal triangle, one entry per cycle after CLEAR, ending in DONE
    task automatic build(input int l, input int h, input int n);
        exp_t e;
        int   t;
        t = 0;
        for (int i = 0; i < l; i++) begin
            e.c = 17'(i); e.t = 8'(t); e.d = 1'b0; sb.push_back(e);
        end
        for (int s = 0; s < n; s++) begin
            for (int v = l; v < h; v++) begin
                e.c = 17'(v); e.t = 8'(t); e.d = 1'b0; sb.push_back(e);
            end
            for (int v = h; v > l; v--) begin
                e.c = 17'(v); e.t = 8'(t); e.d = 1'b0; sb.push_back(e);
            end
            t++;
        end
        e.c = 17'(l); e.t = 8'(n); e.d = 1'b1; sb.push_back(e);
    endtask

    task automatic run_sweep(input int l, input int h, input int n, input int inject);
        exp_t e;
        int   idx;
        lo_i = 17'(l); hi_i = 17'(h); sweeps_i = 8'(n); start = 1'b1;
        step();
        start = 1'b0;
        chk("clear_busy", 32'(busy), 32'd1);
        chk("clear_zero", 32'(cnt_zero), 32'd1);
        chk("clear_en", 32'(cnt_en), 32'd0);
        chk("clear_trips", 32'(trips), 32'd0);
        build(l, h, n);
        idx = 0;
        while (sb.size() > 0) begin
            if (idx == inject) begin
                start = 1'b1; lo_i = 17'd0; hi_i = 17'd10; sweeps_i = 8'd5;
            end
            step();
            start = 1'b0;
            e = sb.pop_front();
            chk("cnt", 32'(cnt), 32'(e.c));
            chk("trips", 32'(trips), 32'(e.t));
            chk("done", 32'(done), 32'(e.d));
            chk("en", 32'(cnt_en), 32'(!e.d));
            idx++;
        end
        step();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_cnt", 32'(cnt), 32'(l));
        chk("post_done", 32'(done), 32'd0);
        chk("post_trips", 32'(trips), 32'(n));
    endtask

    initial begin
        int dones;
        bit found;
        rst = 1'b0; start = 1'b1; stop = 1'b0;
        lo_i = 17'd1; hi_i = 17'd5; sweeps_i = 8'd1;
        step();
        step();
        chk("rst_en", 32'(cnt_en), 32'd0);
        chk("rst_dir", 32'(cnt_dir), 32'd0);
        chk("rst_zero", 32'(cnt_zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_trips", 32'(trips), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd77);
        rst = 1'b1; start = 1'b0;
        step();

        run_sweep(3, 6, 2, -1);
        run_sweep(0, 1, 3, -1);

        // Rejected starts: equal and inverted bounds
        lo_i = 17'd5; hi_i = 17'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("err_eq", 32'(err), 32'd1);
        chk("err_eq_busy", 32'(busy), 32'd0);
        chk("err_eq_en", 32'(cnt_en), 32'd0);
        step();
        chk("err_eq_pulse", 32'(err), 32'd0);
        chk("err_eq_trips", 32'(trips), 32'd3);
        lo_i = 17'd9; hi_i = 17'd4; start = 1'b1;
        step();
        start = 1'b0;
        chk("err_inv", 32'(err), 32'd1);
        chk("err_inv_busy", 32'(busy), 32'd0);
        step();
        chk("err_inv_pulse", 32'(err), 32'd0);
        chk("err_inv_en", 32'(cnt_en), 32'd0);

        // Start and stop together in IDLE
        lo_i = 17'd1; hi_i = 17'd3; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", 32'(busy), 32'd0);
        chk("ss_err", 32'(err), 32'd0);
        chk("ss_zero", 32'(cnt_zero), 32'd0);

        // Start pulse while busy must not disturb the run
        run_sweep(1, 3, 1, 2);

        // Endless run aborted at the peak of the third triangle
        lo_i = 17'd2; hi_i = 17'd4; sweeps_i = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        dones = 0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (done) dones++;
            if (cnt == 17'd4 && trips == 8'd2) found = 1'b1;
        end
        chk("inf_reached", 32'(found), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_en", 32'(cnt_en), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_cnt", 32'(cnt), 32'd3);
        chk("stop_trips", 32'(trips), 32'd2);
        chk("stop_done", 32'(done), 32'd0);
        step();
        chk("stop_frozen", 32'(cnt), 32'd3);
        chk("stop_err", 32'(err), 32'd0);
        chk("inf_dones", 32'(dones), 32'd0);

        // Reset in the middle of a sweep
        lo_i = 17'd0; hi_i = 17'd8; sweeps_i = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        step();
        chk("mid_rst_en", 32'(cnt_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_trips", 32'(trips), 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd3);
        rst = 1'b1;
        step();
        chk("mid_rst_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
